barrido_teclado: RTL and testbench
==================================

BARRIDO_TECLADO -- requirements
Module: barrido_teclado

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven while scanning; legal range >= 4.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a press or a release; legal range >= 1.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port fila, input, 4: keypad row lines; active-low, pulled up; asynchronous to clk.
REQ-006 SHALL have port columna, output, 4: keypad column drive; one-hot active-low.
REQ-007 SHALL have port input_teclado, output, 6: key code = {2'b00, row[1:0], col[1:0]}; drives the traduccion input directly.
REQ-008 SHALL have port key_detect, output, 1: one-cycle pulse per accepted key press.

Function
REQ-009 SHALL pass fila through a 2-flop synchronizer; all decisions use the synchronized value fila_s.
REQ-010 SHALL implement FSM states SCAN, DEBOUNCE, HELD.
REQ-011 In SCAN, SHALL drive columna = ~(4'b0001 << col_idx) and count dwell cycles 0..SCAN_DIV-1.
REQ-012 SHALL sample fila_s only on the last dwell cycle, so that sync latency is flushed after a column change.
REQ-013 At that sample, if exactly one fila_s bit is low, SHALL capture row index and col_idx and enter DEBOUNCE with the column held.
REQ-014 At that sample, if zero bits or more than one bit are low (ghost or multi-key), SHALL advance col_idx (3 wraps to 0) and restart dwell.
REQ-015 In DEBOUNCE, SHALL keep columna fixed and count cycles where fila_s equals the captured pattern.
REQ-016 Any mismatch in DEBOUNCE SHALL return to SCAN with col_idx advanced and no output change.
REQ-017 After DEBOUNCE_CYCLES consecutive matches, SHALL, in one cycle: update input_teclado to the new code, pulse key_detect high, and enter HELD.
REQ-018 input_teclado SHALL hold its value until the next accepted press; the code is valid in the same cycle as key_detect.
REQ-019 In HELD, SHALL keep columna fixed and count consecutive cycles with fila_s == 4'b1111.
REQ-020 Any low bit in HELD SHALL restart the release count; no auto-repeat pulse occurs.
REQ-021 After DEBOUNCE_CYCLES consecutive all-high cycles, SHALL enter SCAN with col_idx advanced.
REQ-022 key_detect SHALL never be high on two consecutive cycles; at most one pulse occurs per press-release cycle.
REQ-023 Counters SHALL be sized with $clog2 of their parameter and SHALL NOT wrap before their terminal count.

Reset
REQ-024 While rst is high, SHALL set: state SCAN, col_idx 0, columna 4'b1110, input_teclado 6'b000000, key_detect 0, all counters 0, synchronizer flops 4'b1111.
REQ-025 Reset asserted in DEBOUNCE or HELD SHALL abort the state with no key_detect pulse; scanning SHALL restart at column 0 on the first edge after deassertion.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the key-code width (6), and the row/column count (4).
REQ-027 The synchronizer SHALL be one sub-module, sincronizador, parameterized on width, reset to all ones.
REQ-028 Counters and the FSM SHALL live in barrido_teclado; no other sub-modules.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-029 Idle with fila=4'b1111 -> columna cycles 1110,1101,1011,0111,1110, each for 4 cycles; key_detect stays 0.
REQ-030 Hold fila=4'b1110 while columna=4'b1110 for at least 20 cycles -> exactly one key_detect pulse with input_teclado=6'b000000; columna stays 1110 until release plus 8 cycles.
REQ-031 Key at row 3, col 3 -> input_teclado=6'b001111 with the pulse; key at row 3, col 0 -> 6'b001100.
REQ-032 Bounce: row low 3 cycles, high 1 cycle, then low stable -> no pulse from the first attempt; one pulse after 8 stable cycles on a later scan pass.
REQ-033 fila=4'b1100 (two rows low) -> no pulse, and scanning continues.
REQ-034 rst pulsed at DEBOUNCE cycle 5 -> no pulse, outputs take reset values, and scan restarts at columna=4'b1110.

Source files
------------

// File: rtl/barrido_teclado_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner.
// Holds the FSM state encoding plus small helpers for decoding the row lines.
package barrido_teclado_pkg;

  localparam int KEY_W   = 6;
  localparam int N_LINES = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } estado_t;

  // True when exactly one bit of the active-high vector is set.
  function automatic logic es_unico(input logic [N_LINES-1:0] activos);
    return (activos != '0) && ((activos & (activos - 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] fila_a_indice(input logic [N_LINES-1:0] activos);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_LINES; i++) begin
      if (activos[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages reset to all ones so idle pulled-up lines read as released.
module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/barrido_teclado.sv
// 4x4 keypad scanner: drives one column low at a time, debounces a single-key
// press, emits a one-cycle key_detect pulse with the key code, then waits for release.
module barrido_teclado
  import barrido_teclado_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] fila,
  output logic [N_LINES-1:0] columna,
  output logic [KEY_W-1:0]   input_teclado,
  output logic               key_detect
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_LINES-1:0] fila_s;
  estado_t            state_q;
  logic [1:0]         col_idx_q;
  logic [1:0]         row_q;
  logic [N_LINES-1:0] patron_q;
  logic [N_LINES-1:0] columna_q;
  logic [KEY_W-1:0]   code_q;
  logic               key_detect_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DEB_W-1:0]   deb_q;
  logic [1:0]         col_idx_d;
  logic [N_LINES-1:0] columna_d;

  sincronizador #(
    .WIDTH(N_LINES)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (fila),
    .q_o  (fila_s)
  );

  // Column to move to whenever a scan step gives up on the current one.
  assign col_idx_d = col_idx_q + 2'd1;
  assign columna_d = ~(4'b0001 << col_idx_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SCAN;
      col_idx_q    <= 2'd0;
      row_q        <= 2'd0;
      patron_q     <= '1;
      columna_q    <= 4'b1110;
      code_q       <= '0;
      key_detect_q <= 1'b0;
      dwell_q      <= '0;
      deb_q        <= '0;
    end else begin
      key_detect_q <= 1'b0;
      case (state_q)
        SCAN: begin
          // Rows are only trusted on the last dwell cycle, after sync latency.
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (es_unico(~fila_s)) begin
              state_q  <= DEBOUNCE;
              patron_q <= fila_s;
              row_q    <= fila_a_indice(~fila_s);
              deb_q    <= '0;
            end else begin
              col_idx_q <= col_idx_d;
              columna_q <= columna_d;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (fila_s != patron_q) begin
            state_q   <= SCAN;
            col_idx_q <= col_idx_d;
            columna_q <= columna_d;
            dwell_q   <= '0;
            deb_q     <= '0;
          end else if (deb_q == DEB_LAST) begin
            state_q      <= HELD;
            deb_q        <= '0;
            code_q       <= {2'b00, row_q, col_idx_q};
            key_detect_q <= 1'b1;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        HELD: begin
          if (fila_s != '1) begin
            deb_q <= '0;
          end else if (deb_q == DEB_LAST) begin
            state_q   <= SCAN;
            col_idx_q <= col_idx_d;
            columna_q <= columna_d;
            dwell_q   <= '0;
            deb_q     <= '0;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign columna       = columna_q;
  assign input_teclado = code_q;
  assign key_detect    = key_detect_q;

endmodule

// File: tb/tb_barrido_teclado.sv
// Self-checking bench for barrido_teclado with a behavioural 4x4 keypad model.
// Expected codes come from the pressed key position; column order from the scan rules.
module tb_barrido_teclado;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fila;
  logic [3:0] columna;
  logic [5:0] input_teclado;
  logic       key_detect;

  logic       pressed  = 1'b0;
  logic [1:0] pressRow = 2'd0;
  logic [1:0] pressCol = 2'd0;
  logic [3:0] glitch   = 4'h0;
  logic       forceEn  = 1'b0;
  logic [3:0] forceVal = 4'hF;
  logic [3:0] keypadFila;

  int         assertCount = 0;
  int         failCount   = 0;
  int         pulseCount  = 0;
  logic [5:0] lastCode    = 6'h3F;
  logic       prevKd      = 1'b0;

  barrido_teclado #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fila         (fila),
    .columna      (columna),
    .input_teclado(input_teclado),
    .key_detect   (key_detect)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row low only while its column is driven low.
  always_comb begin
    keypadFila = 4'hF;
    if (pressed && columna[pressCol] == 1'b0) keypadFila[pressRow] = 1'b0;
  end

  assign fila = forceEn ? forceVal : (keypadFila | glitch);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic press, input logic [1:0] r, input logic [1:0] c,
                               input int cycles);
    pressed  = press;
    pressRow = r;
    pressCol = c;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic waitColStart();
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    prev  = columna;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (columna == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = columna;
    end
    checkOutput("col0_start_found", 32'(found), 32'd1);
  endtask

  task automatic checkScanAfterReset(input int steps);
    logic [3:0] expCol;
    rst = 1'b0;
    for (int k = 0; k < steps; k++) begin
      if (k > 0) step();
      expCol = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      checkOutput("scan_order", 32'(columna), 32'(expCol));
    end
  endtask

  // Pulse monitor: records every accepted key and its code.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_detect === 1'b1) begin
        checkOutput("no_back_to_back", 32'(prevKd), 32'd0);
        pulseCount++;
        lastCode = input_teclado;
      end
      checkOutput("columna_onehot", 32'($countones(~columna)), 32'd1);
      prevKd = key_detect;
    end else begin
      prevKd = 1'b0;
    end
  end

  initial begin
    int         base;
    int         moves;
    logic       seenMove;
    logic [3:0] prevCol;
    logic [1:0] r;
    logic [1:0] c;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checkOutput("reset_columna", 32'(columna), 32'h0E);
    checkOutput("reset_code", 32'(input_teclado), 32'h00);
    checkOutput("reset_kd", 32'(key_detect), 32'h0);

    checkScanAfterReset(20);
    checkOutput("idle_no_pulse", 32'(pulseCount), 32'd0);

    // Key row 0 / column 0 held well past debounce.
    base = pulseCount;
    applyStimulus(1'b1, 2'd0, 2'd0, 40);
    checkOutput("k00_pulses", 32'(pulseCount - base), 32'd1);
    checkOutput("k00_code", 32'(lastCode), 32'h00);
    checkOutput("k00_held_col", 32'(columna), 32'h0E);
    pressed = 1'b0;
    for (int i = 0; i < DEB; i++) begin
      step();
      checkOutput("k00_release_hold", 32'(columna), 32'h0E);
    end
    applyStimulus(1'b0, 2'd0, 2'd0, 30);

    base = pulseCount;
    applyStimulus(1'b1, 2'd3, 2'd3, 60);
    checkOutput("k33_pulses", 32'(pulseCount - base), 32'd1);
    checkOutput("k33_code", 32'(lastCode), 32'h0F);
    applyStimulus(1'b0, 2'd0, 2'd0, 30);

    base = pulseCount;
    applyStimulus(1'b1, 2'd3, 2'd0, 60);
    checkOutput("k30_pulses", 32'(pulseCount - base), 32'd1);
    checkOutput("k30_code", 32'(lastCode), 32'h0C);
    applyStimulus(1'b0, 2'd0, 2'd0, 30);

    // Reset in the middle of debounce aborts the press.
    base = pulseCount;
    waitColStart();
    applyStimulus(1'b1, 2'd2, 2'd0, 8);
    rst     = 1'b1;
    pressed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_mid_columna", 32'(columna), 32'h0E);
      checkOutput("rst_mid_code", 32'(input_teclado), 32'h00);
      checkOutput("rst_mid_kd", 32'(key_detect), 32'h0);
    end
    checkOutput("rst_mid_no_pulse", 32'(pulseCount - base), 32'd0);
    checkScanAfterReset(8);
    applyStimulus(1'b0, 2'd0, 2'd0, 10);

    // Bounce: three low cycles, one high, then stable low.
    base = pulseCount;
    waitColStart();
    applyStimulus(1'b1, 2'd0, 2'd0, 3);
    glitch = 4'hF;
    step();
    glitch   = 4'h0;
    seenMove = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (columna != 4'b1110) seenMove = 1'b1;
    end
    checkOutput("bounce_rescan", 32'(seenMove), 32'd1);
    checkOutput("bounce_first_no_pulse", 32'(pulseCount - base), 32'd0);
    applyStimulus(1'b1, 2'd0, 2'd0, 60);
    checkOutput("bounce_pulses", 32'(pulseCount - base), 32'd1);
    checkOutput("bounce_code", 32'(lastCode), 32'h00);
    applyStimulus(1'b0, 2'd0, 2'd0, 30);

    // Two rows low at once: ghost, never accepted.
    base    = pulseCount;
    forceEn = 1'b1;
    forceVal = 4'b1100;
    moves   = 0;
    prevCol = columna;
    for (int i = 0; i < 60; i++) begin
      step();
      if (columna != prevCol) moves++;
      prevCol = columna;
    end
    forceEn = 1'b0;
    checkOutput("ghost_no_pulse", 32'(pulseCount - base), 32'd0);
    checkOutput("ghost_keeps_scanning", 32'(moves >= 8), 32'd1);
    applyStimulus(1'b0, 2'd0, 2'd0, 10);

    for (int n = 0; n < 6; n++) begin
      r    = 2'($urandom_range(0, 3));
      c    = 2'($urandom_range(0, 3));
      base = pulseCount;
      applyStimulus(1'b1, r, c, 80);
      checkOutput("rand_pulses", 32'(pulseCount - base), 32'd1);
      checkOutput("rand_code", 32'(lastCode), 32'({2'b00, r, c}));
      checkOutput("rand_held_col", 32'(columna), 32'(4'(~(4'b0001 << c))));
      applyStimulus(1'b0, 2'd0, 2'd0, 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
